i2c_byte_writer: RTL and testbench
==================================

I2C_BYTE_WRITER -- requirements
Module: i2c_byte_writer

Interface
REQ-001 The block SHALL have parameter QUARTER_CYCLES, default 68, giving clk cycles per SCL quarter-period (about 100 kHz at 27 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port address, input, 8 bits: first byte sent (7-bit address plus R/W, e.g. 8'h78).
REQ-005 The block SHALL have port control, input, 8 bits: second byte sent (SSD1306 control byte).
REQ-006 The block SHALL have port data, input, 8 bits: third byte sent (command or data).
REQ-007 The block SHALL have port op_start, input, 1 bit: level request for one 3-byte write.
REQ-008 The block SHALL have port op_done, output, 1 bit: transaction complete, held until op_start is low.
REQ-009 The block SHALL have port busy, output, 1 bit: high from acceptance until return to IDLE.
REQ-010 The block SHALL have port ack_error, output, 1 bit: a NACK occurred in the last transaction.
REQ-011 The block SHALL have port sck, inout, 1 bit: I2C SCL, open-drain, driving 0 or Z only.
REQ-012 The block SHALL have port sda, inout, 1 bit: I2C SDA, open-drain, driving 0 or Z only; it is read for ACK.

Function
REQ-013 States SHALL be IDLE, START, BIT, ACK, STOP and DONE.
REQ-014 A quarter-period counter SHALL count 0..QUARTER_CYCLES-1 and advance the quarter index q (0..3) on wrap.
  - It runs only outside IDLE and DONE.
  - It is cleared to 0 on acceptance.
REQ-015 In IDLE with op_start=1, the block SHALL latch address, control and data into a 24-bit shift register and enter START on the next edge.
  - busy=1 and ack_error=0 from that edge.
REQ-016 START timing SHALL be as follows.
  - q0-q1: SCL=Z, SDA=Z.
  - q2-q3: SCL=Z, SDA=0.
  - Then go to BIT with bit index 7 and byte index 0.
REQ-017 Each BIT SHALL be timed as follows.
  - q0-q1: SCL=0, with SDA set at q0 start to the shift-register MSB (1 gives Z, 0 gives 0).
  - q2-q3: SCL=Z.
  - SDA is stable while SCL is released.
REQ-018 Bits SHALL be sent MSB first; after bit 0 the state SHALL go to ACK.
REQ-019 ACK SHALL be timed as follows.
  - q0-q1: SCL=0, SDA=Z.
  - q2-q3: SCL=Z.
  - sda is sampled on the last clk of q2.
REQ-020 On sampled ACK (sda=0), the byte index SHALL advance.
  - Indices 0 and 1 go back to BIT.
  - Index 2 goes to STOP.
REQ-021 On sampled NACK (sda=1), the block SHALL set ack_error=1 and go directly to STOP, skipping remaining bytes.
REQ-022 STOP timing SHALL be as follows.
  - q0-q1: SCL=0, SDA=0.
  - q2: SCL=Z, SDA=0.
  - q3: SCL=Z, SDA=Z.
  - Then go to DONE.
REQ-023 In DONE the block SHALL hold op_done=1 while op_start=1.
  - When op_start=0 it SHALL clear op_done and busy on the next edge and enter IDLE.
REQ-024 Full-success latency SHALL be exactly 116*QUARTER_CYCLES+1 clk edges from the accepting edge to op_done rising.
  - START is 4 quarters, the bytes are 27 bit-slots of 4 quarters each, STOP is 4 quarters.
REQ-025 With op_start held high in DONE, no new transaction SHALL start.
  - A new transaction requires op_start low, then IDLE, then op_start high again.
REQ-026 Changes on address, control or data after acceptance SHALL NOT affect the transaction in flight.
REQ-027 op_start deasserting mid-transaction SHALL be ignored; the transaction SHALL complete through STOP and DONE.
REQ-028 In IDLE the bus SHALL be released (SCL=Z, SDA=Z).
REQ-029 ack_error SHALL hold its value until the next acceptance.

Reset
REQ-030 While rst=1, independent of clk, the block SHALL hold:
  - state IDLE with all counters 0;
  - op_done=0, busy=0, ack_error=0;
  - sck and sda at Z.
REQ-031 Reset asserted mid-transaction SHALL release the bus immediately without generating STOP, and the block SHALL accept a new op_start in the first cycle after rst falls.

Verification (QUARTER_CYCLES=4; pull-ups modelled; slave model ACKs unless stated)
REQ-032 Send address=78, control=00, data=8D, op_start held high -> decoded bytes are 78, 00, 8D, each ACKed; START and STOP are legal; op_done rises exactly 465 clk after acceptance; ack_error=0.
REQ-033 Slave NACKs the address byte -> no further data bits are sent; STOP follows the first ACK slot; op_done=1 and ack_error=1.
REQ-034 op_start held high after op_done -> op_done stays 1 and no second START appears; drop op_start -> op_done=0 and busy=0 one edge later; a new op_start with data=AF produces a second transaction.
REQ-035 Change data from 8D to FF one cycle after acceptance -> the bus still carries 8D.
REQ-036 Assert rst mid-way through the control byte -> sck and sda are Z asynchronously and all outputs are 0; after rst falls, a new transaction (78, 00, 14) completes correctly.
REQ-037 Bus assertion checker on every test -> SDA never changes while SCL is released, except at the START and STOP edges.

Source files
------------

// File: rtl/i2c_byte_writer.sv
// Open-drain I2C master that writes one 3-byte transaction (address, control, data),
// e.g. for an SSD1306 display. Each SCL period is split into four quarters.
module i2c_byte_writer #(
  parameter int unsigned QUARTER_CYCLES = 68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] control,
  input  logic [7:0] data,
  input  logic       op_start,
  output logic       op_done,
  output logic       busy,
  output logic       ack_error,
  inout  wire        sck,
  inout  wire        sda
);

  localparam int unsigned CNT_W = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [23:0]      shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             ack_smp_q, ack_smp_d;
  logic             scl_low_q, scl_low_d;
  logic             sda_low_q, sda_low_d;

  logic tick;
  logic last_qtr;

  assign tick     = (cnt_q == CNT_LAST);
  assign last_qtr = tick && (qtr_q == 2'd3);

  // Bus pins only ever pull low; pull-ups supply the high level.
  assign sck = scl_low_q ? 1'b0 : 1'bz;
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign op_done   = done_q;
  assign busy      = busy_q;
  assign ack_error = ack_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 24'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      ack_smp_q <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      ack_smp_q <= ack_smp_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ack_err_d = ack_err_q;
    ack_smp_d = ack_smp_q;
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;

    if (state_q != IDLE && state_q != DONE) begin
      cnt_d = tick ? '0 : CNT_W'(cnt_q + 1'b1);
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (op_start) begin
          shift_d   = {address, control, data};
          state_d   = START;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          cnt_d     = '0;
          qtr_d     = 2'd0;
        end
      end
      START: begin
        if (last_qtr) begin
          state_d = BIT;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
        end
      end
      BIT: begin
        if (last_qtr) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_q == 3'd0) begin
            state_d = ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ACK: begin
        // Sample the slave's answer at the end of the first released-SCL quarter.
        if (tick && qtr_q == 2'd2) begin
          ack_smp_d = sda;
        end
        if (last_qtr) begin
          if (ack_smp_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (byte_q == 2'd2) begin
            state_d = STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
            state_d = BIT;
          end
        end
      end
      STOP: begin
        if (last_qtr) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (op_start) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin drive is derived from the next state so it lines up with the quarter it belongs to.
    unique case (state_d)
      START: begin
        sda_low_d = qtr_d[1];
      end
      BIT: begin
        scl_low_d = ~qtr_d[1];
        sda_low_d = ~shift_d[23];
      end
      ACK: begin
        scl_low_d = ~qtr_d[1];
      end
      STOP: begin
        scl_low_d = ~qtr_d[1];
        sda_low_d = (qtr_d != 2'd3);
      end
      default: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_writer.sv
// Scoreboard bench for i2c_byte_writer: a bus decoder plus slave model checks the wire
// traffic, and a completion monitor checks op_done latency and ack_error.
module tb_i2c_byte_writer;

  localparam int unsigned Q = 4;
  localparam int FULL_LAT = 116 * Q + 1;

  typedef struct {
    logic [7:0] b [3];
    int         nbytes;
    int         nack_idx;
  } bus_exp_t;

  typedef struct {
    int   acc_cyc;
    int   lat;
    logic ack_err;
  } done_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_start;
  logic [7:0] address, control, data;
  logic       op_done, busy, ack_error;
  wire        sck, sda;
  logic       slv_low = 1'b0;

  pullup (sck);
  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_byte_writer #(.QUARTER_CYCLES(Q)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .control  (control),
    .data     (data),
    .op_start (op_start),
    .op_done  (op_done),
    .busy     (busy),
    .ack_error(ack_error),
    .sck      (sck),
    .sda      (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Bus decoder and slave: START/STOP when SDA moves with SCL high, bits on SCL rise.
  logic       pscl = 1'b1, psda = 1'b1, in_frame = 1'b0;
  int         nbits = 0;
  logic [8:0] sh = '0;
  logic [7:0] got[$];
  logic       ackv[$];
  bus_exp_t   cur;
  always @(negedge clk) begin
    logic s, d;
    bus_exp_t e;
    s = sck;
    d = sda;
    if (rst) begin
      in_frame = 1'b0;
      slv_low  = 1'b0;
    end else if (pscl && s && psda && !d) begin
      chk("start_outside_frame", int'(in_frame), 0);
      if (bus_q.size() == 0) begin
        fail_now("unexpected_start");
        cur.nack_idx = -1;
      end else begin
        cur = bus_q[0];
      end
      in_frame = 1'b1;
      nbits = 0;
      got.delete();
      ackv.delete();
    end else if (pscl && s && !psda && d) begin
      if (!in_frame) begin
        fail_now("stray_stop");
      end else begin
        chk("stop_position", nbits % 9, 1);
        if (bus_q.size() == 0) begin
          fail_now("stop_without_expectation");
        end else begin
          e = bus_q.pop_front();
          chk("byte_count", got.size(), e.nbytes);
          for (int i = 0; i < e.nbytes && i < got.size(); i++) begin
            chk($sformatf("byte%0d", i), int'(got[i]), int'(e.b[i]));
            chk($sformatf("ack%0d", i), int'(ackv[i]), (i == e.nack_idx) ? 1 : 0);
          end
        end
      end
      in_frame = 1'b0;
      slv_low  = 1'b0;
    end else if (!pscl && s && in_frame) begin
      sh = {sh[7:0], d};
      nbits++;
      if (nbits % 9 == 8) got.push_back(sh[7:0]);
      else if (nbits % 9 == 0) ackv.push_back(d);
    end else if (pscl && !s && in_frame) begin
      slv_low = (nbits % 9 == 8) && ((nbits / 9) != cur.nack_idx);
    end
    pscl = s;
    psda = d;
  end

  // Completion monitor: op_done rising edge against the expected latency and status.
  logic pdone = 1'b0;
  always @(negedge clk) begin
    done_exp_t e;
    if (!rst && op_done && !pdone) begin
      if (done_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        e = done_q.pop_front();
        chk("done_latency", cyc - e.acc_cyc, e.lat);
        chk("done_ack_error", int'(ack_error), int'(e.ack_err));
        chk("busy_at_done", int'(busy), 1);
      end
    end
    pdone = rst ? 1'b0 : op_done;
  end

  task automatic start_txn(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d,
                           input int nack, input bit expect_done, output int acc);
    bus_exp_t  be;
    done_exp_t de;
    @(negedge clk);
    address  = a;
    control  = c;
    data     = d;
    op_start = 1'b1;
    be.b[0] = a;
    be.b[1] = c;
    be.b[2] = d;
    be.nack_idx = (nack < 0) ? -1 : nack;
    be.nbytes   = (nack < 0) ? 3 : nack + 1;
    bus_q.push_back(be);
    acc = cyc + 1;
    de.acc_cyc = acc;
    de.lat     = int'(Q) * (8 + 36 * be.nbytes) + 1;
    de.ack_err = (nack >= 0);
    if (expect_done) done_q.push_back(de);
    @(posedge clk);
    #1;
    chk("busy_on_accept", int'(busy), 1);
    chk("ack_error_cleared", int'(ack_error), 0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (op_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  task automatic finish_txn(input int hold, input logic exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_held", int'(op_done), 1);
      chk("busy_held", int'(busy), 1);
    end
    @(negedge clk);
    op_start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_cleared", int'(op_done), 0);
    chk("busy_cleared", int'(busy), 0);
    chk("ack_error_kept", int'(ack_error), int'(exp_err));
  endtask

  initial begin
    int   acc;
    int   nack;
    bit   ok;
    logic [7:0] a, c, d;

    rst = 1'b1;
    op_start = 1'b0;
    address = 8'h00;
    control = 8'h00;
    data = 8'h00;
    #1;
    chk("reset_done", int'(op_done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack_error", int'(ack_error), 0);
    chk("reset_sck_released", int'(sck), 1);
    chk("reset_sda_released", int'(sda), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Plain 3-byte write.
    start_txn(8'h78, 8'h00, 8'h8D, -1, 1'b1, acc);
    wait_done();
    finish_txn(2, 1'b0);

    // Address NACK ends the frame after the first ACK slot.
    start_txn(8'h78, 8'h00, 8'h8D, 0, 1'b1, acc);
    wait_done();
    finish_txn(1, 1'b1);

    // Long hold in DONE must not restart, then a second write.
    start_txn(8'h78, 8'h40, 8'h8D, -1, 1'b1, acc);
    wait_done();
    finish_txn(40, 1'b0);
    start_txn(8'h78, 8'h00, 8'hAF, -1, 1'b1, acc);
    wait_done();
    finish_txn(0, 1'b0);

    // Inputs changed right after acceptance are ignored.
    start_txn(8'h78, 8'h00, 8'h8D, -1, 1'b1, acc);
    data = 8'hFF;
    address = 8'h11;
    wait_done();
    finish_txn(1, 1'b0);

    // op_start dropped mid-flight: frame still completes; busy falls one edge after DONE.
    start_txn(8'h78, 8'h80, 8'h3C, -1, 1'b0, acc);
    repeat (50) @(negedge clk);
    op_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("busy_timeout");
    else chk("busy_fall_latency", cyc - acc, FULL_LAT);

    // Reset in the middle of the control byte.
    start_txn(8'h78, 8'h00, 8'h8D, -1, 1'b1, acc);
    repeat (224) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sck", int'(sck), 1);
    chk("midrst_sda", int'(sda), 1);
    chk("midrst_done", int'(op_done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ack_error", int'(ack_error), 0);
    bus_q.delete();
    done_q.delete();
    op_start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    start_txn(8'h78, 8'h00, 8'h14, -1, 1'b1, acc);
    wait_done();
    finish_txn(0, 1'b0);

    // Random bytes, random NACK position, random hold, scrambled inputs after acceptance.
    for (int t = 0; t < 8; t++) begin
      a = 8'($urandom);
      c = 8'($urandom);
      d = 8'($urandom);
      nack = int'($urandom_range(0, 5)) - 3;
      start_txn(a, c, d, nack, 1'b1, acc);
      address = 8'($urandom);
      control = 8'($urandom);
      data = 8'($urandom);
      wait_done();
      finish_txn(int'($urandom_range(0, 5)), (nack >= 0));
    end

    repeat (20) @(negedge clk);
    if (bus_q.size() != 0) fail_now("bus_frames_missing");
    if (done_q.size() != 0) fail_now("done_events_missing");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
